// File: rtl/z80_resets.sv
// Reset conditioner for the Z80 core: turns the external reset pin into the internal
// active-low core reset and a PC-clear strobe, separating full resets from special resets.
module z80_resets #(
    parameter int CLRPC_TAIL = 2
) (
    input  logic clk,
    input  logic nfpga_reset,
    input  logic reset_in,
    input  logic M1,
    input  logic T2,
    input  logic nhold_clk_wait,
    output logic nreset,
    output logic clrpc
);

    // state        | meaning
    // MODE_FULL    | clrpc belongs to a full reset; released by the tail counter
    // MODE_SPECIAL | clrpc belongs to a special reset; released by the next M1&T2
    typedef enum logic {
        MODE_FULL    = 1'b0,
        MODE_SPECIAL = 1'b1
    } mode_t;

    localparam int TW = $clog2(CLRPC_TAIL + 1);
    localparam logic [TW-1:0] TAIL_LOAD = TW'(CLRPC_TAIL - 1);

    logic          r_r1;
    logic          r_cand;
    logic          r_nreset;
    logic          r_clrpc;
    mode_t         r_mode;
    logic [TW-1:0] r_tail;

    logic          w_special;
    logic          w_nreset_nxt;
    logic          w_clrpc_nxt;
    mode_t         w_mode_nxt;
    logic [TW-1:0] w_tail_nxt;

    always_comb begin
        w_special    = r_r1 & r_cand & ~reset_in;
        w_nreset_nxt = ~(r_r1 & ~w_special);
        w_clrpc_nxt  = r_clrpc;
        w_mode_nxt   = r_mode;
        w_tail_nxt   = r_tail;
        if (nhold_clk_wait) begin
            // The tail is preloaded while nreset is low and reloaded on the release edge,
            // so a full reset always overrides whatever clrpc was doing.
            if (!w_nreset_nxt || !r_nreset) begin
                w_clrpc_nxt = 1'b1;
                w_mode_nxt  = MODE_FULL;
                w_tail_nxt  = TAIL_LOAD;
            end else if (w_special) begin
                w_clrpc_nxt = 1'b1;
                w_mode_nxt  = MODE_SPECIAL;
            end else if (r_clrpc && (r_mode == MODE_FULL)) begin
                if (r_tail == '0) begin
                    w_clrpc_nxt = 1'b0;
                end else begin
                    w_tail_nxt = r_tail - TW'(1);
                end
            end else if (r_clrpc && M1 && T2) begin
                w_clrpc_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nfpga_reset) begin
            r_r1     <= 1'b0;
            r_cand   <= 1'b0;
            r_nreset <= 1'b1;
            r_clrpc  <= 1'b0;
            r_mode   <= MODE_FULL;
            r_tail   <= '0;
        end else begin
            r_r1     <= reset_in;
            r_cand   <= reset_in & M1 & ~T2;
            r_nreset <= w_nreset_nxt;
            r_clrpc  <= w_clrpc_nxt;
            r_mode   <= w_mode_nxt;
            r_tail   <= w_tail_nxt;
        end
    end

    assign nreset = r_nreset;
    assign clrpc  = r_clrpc;

endmodule

// File: tb/tb_z80_resets.sv
// Bench for z80_resets: directed reset scenarios with fixed expectations, then a long
// randomized run checked against a pin-history reference model.
module tb_z80_resets;

    localparam int CLRPC_TAIL = 2;

    logic clk;
    logic nfpga_reset;
    logic reset_in;
    logic M1;
    logic T2;
    logic nhold_clk_wait;
    logic nreset;
    logic clrpc;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_nres;
    bit m_clr;
    bit m_special_mode;
    int m_since;
    bit h_rin;
    bit h_cand;

    z80_resets #(.CLRPC_TAIL(CLRPC_TAIL)) dut (
        .clk            (clk),
        .nfpga_reset    (nfpga_reset),
        .reset_in       (reset_in),
        .M1             (M1),
        .T2             (T2),
        .nhold_clk_wait (nhold_clk_wait),
        .nreset         (nreset),
        .clrpc          (clrpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // m_since counts completed edges since a full reset released; clrpc lasts CLRPC_TAIL of them.
    task automatic model_edge(input bit rin, input bit m1, input bit t2, input bit nh, input bit nfr);
        bit pulse;
        bit nres_next;
        if (!nfr) begin
            h_rin          = 1'b0;
            h_cand         = 1'b0;
            m_nres         = 1'b1;
            m_clr          = 1'b0;
            m_special_mode = 1'b0;
            m_since        = CLRPC_TAIL;
            return;
        end
        pulse     = h_rin && h_cand && !rin;
        nres_next = !(h_rin && !pulse);
        if (nh) begin
            if (!nres_next || !m_nres) begin
                m_clr          = 1'b1;
                m_special_mode = 1'b0;
                m_since        = 1;
            end else if (pulse) begin
                m_clr          = 1'b1;
                m_special_mode = 1'b1;
            end else if (m_clr && !m_special_mode) begin
                m_since++;
                if (m_since > CLRPC_TAIL) m_clr = 1'b0;
            end else if (m_clr && m1 && t2) begin
                m_clr = 1'b0;
            end
        end
        m_nres = nres_next;
        h_rin  = rin;
        h_cand = rin && m1 && !t2;
    endtask

    task automatic drive_edge(input bit rin, input bit m1, input bit t2, input bit nh, input bit nfr);
        reset_in       = rin;
        M1             = m1;
        T2             = t2;
        nhold_clk_wait = nh;
        nfpga_reset    = nfr;
        @(posedge clk);
        model_edge(rin, m1, t2, nh, nfr);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_edge(0, 0, 0, 1, 0);
        total++;
        if (nreset !== 1'b1 || clrpc !== 1'b0) begin
            bad++;
            $display("FAIL reset: nreset=%b clrpc=%b, expected 1 0", nreset, clrpc);
        end
        drive_edge(0, 0, 0, 1, 1);
        total++;
        if (nreset !== 1'b1 || clrpc !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: nreset=%b clrpc=%b, expected 1 0", nreset, clrpc);
        end
    endtask

    task automatic test_full();
        bit rin [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        bit en  [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
        bit ec  [9] = '{0, 1, 1, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive_edge(rin[i], 0, 0, 1, 1);
            total++;
            if (nreset !== en[i] || clrpc !== ec[i]) begin
                bad++;
                $display("FAIL full edge %0d: nreset=%b clrpc=%b, expected %b %b", i, nreset, clrpc, en[i], ec[i]);
            end
        end
    endtask

    task automatic test_special();
        bit rin [8] = '{1, 0, 0, 0, 0, 0, 0, 0};
        bit m1  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        bit t2  [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
        bit ec  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            drive_edge(rin[i], m1[i], t2[i], 1, 1);
            total++;
            if (nreset !== 1'b1 || clrpc !== ec[i]) begin
                bad++;
                $display("FAIL special edge %0d: nreset=%b clrpc=%b, expected 1 %b", i, nreset, clrpc, ec[i]);
            end
        end
    endtask

    task automatic test_hold();
        bit rin [6] = '{1, 0, 0, 0, 0, 0};
        bit m1  [6] = '{1, 0, 1, 1, 0, 1};
        bit t2  [6] = '{0, 0, 1, 1, 0, 1};
        bit nh  [6] = '{1, 1, 0, 0, 1, 1};
        bit ec  [6] = '{0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            drive_edge(rin[i], m1[i], t2[i], nh[i], 1);
            total++;
            if (nreset !== 1'b1 || clrpc !== ec[i]) begin
                bad++;
                $display("FAIL hold edge %0d: nreset=%b clrpc=%b, expected 1 %b", i, nreset, clrpc, ec[i]);
            end
        end
    endtask

    task automatic test_override();
        bit rin [9] = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
        bit m1  [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        bit en  [9] = '{1, 1, 1, 1, 0, 0, 1, 1, 1};
        bit ec  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        for (int i = 0; i < 9; i++) begin
            drive_edge(rin[i], m1[i], 0, 1, 1);
            total++;
            if (nreset !== en[i] || clrpc !== ec[i]) begin
                bad++;
                $display("FAIL override edge %0d: nreset=%b clrpc=%b, expected %b %b", i, nreset, clrpc, en[i], ec[i]);
            end
        end
    endtask

    task automatic test_pulse(input bit m1t2);
        bit rin [5] = '{1, 0, 0, 0, 0};
        bit en  [5] = '{1, 0, 1, 1, 1};
        bit ec  [5] = '{0, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive_edge(rin[i], m1t2, m1t2, 1, 1);
            total++;
            if (nreset !== en[i] || clrpc !== ec[i]) begin
                bad++;
                $display("FAIL pulse(m1t2=%b) edge %0d: nreset=%b clrpc=%b, expected %b %b", m1t2, i, nreset, clrpc, en[i], ec[i]);
            end
        end
    endtask

    task automatic test_random(input int n);
        bit rin;
        bit m1;
        bit t2;
        bit nh;
        bit nfr;
        for (int i = 0; i < n; i++) begin
            rin = ($urandom_range(0, 99) < 25);
            m1  = $urandom_range(0, 1) == 1;
            t2  = ($urandom_range(0, 99) < 40);
            nh  = ($urandom_range(0, 99) < 85);
            nfr = ($urandom_range(0, 199) != 0);
            drive_edge(rin, m1, t2, nh, nfr);
            total++;
            if (nreset !== m_nres || clrpc !== m_clr) begin
                bad++;
                $display("FAIL random edge %0d: nreset=%b clrpc=%b, expected %b %b", i, nreset, clrpc, m_nres, m_clr);
            end
        end
    endtask

    initial begin
        nfpga_reset    = 1'b0;
        reset_in       = 1'b0;
        M1             = 1'b0;
        T2             = 1'b0;
        nhold_clk_wait = 1'b1;
        @(negedge clk);
        test_reset();
        test_full();
        test_special();
        test_hold();
        test_override();
        test_pulse(1'b0);
        test_pulse(1'b1);
        test_random(4000);
        test_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
